// File: rtl/det_pkg.sv
// Shared definitions for the sequential Leibniz determinant engine:
// FSM encoding, per-order permutation tables with parity, and term counts.
package det_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Number of Leibniz terms (n!) for order size+1.
  function automatic logic [4:0] term_count(input logic [1:0] size);
    case (size)
      2'd0:    return 5'd1;
      2'd1:    return 5'd2;
      2'd2:    return 5'd6;
      default: return 5'd24;
    endcase
  endfunction

  // Entry layout {odd, col_row0, col_row1, col_row2, col_row3}; lexicographic order.
  // Rows beyond the active order keep the identity column and are masked by det_term.
  function automatic logic [8:0] perm_entry(input logic [1:0] size, input logic [4:0] k);
    logic [8:0] e;
    e = 9'b0_00_01_10_11;
    case (size)
      2'd0: e = 9'b0_00_01_10_11;
      2'd1: e = (k == 5'd0) ? 9'b0_00_01_10_11 : 9'b1_01_00_10_11;
      2'd2: begin
        case (k)
          5'd0:    e = 9'b0_00_01_10_11;
          5'd1:    e = 9'b1_00_10_01_11;
          5'd2:    e = 9'b1_01_00_10_11;
          5'd3:    e = 9'b0_01_10_00_11;
          5'd4:    e = 9'b0_10_00_01_11;
          default: e = 9'b1_10_01_00_11;
        endcase
      end
      default: begin
        case (k)
          5'd0:    e = 9'b0_00_01_10_11;
          5'd1:    e = 9'b1_00_01_11_10;
          5'd2:    e = 9'b1_00_10_01_11;
          5'd3:    e = 9'b0_00_10_11_01;
          5'd4:    e = 9'b0_00_11_01_10;
          5'd5:    e = 9'b1_00_11_10_01;
          5'd6:    e = 9'b1_01_00_10_11;
          5'd7:    e = 9'b0_01_00_11_10;
          5'd8:    e = 9'b0_01_10_00_11;
          5'd9:    e = 9'b1_01_10_11_00;
          5'd10:   e = 9'b1_01_11_00_10;
          5'd11:   e = 9'b0_01_11_10_00;
          5'd12:   e = 9'b0_10_00_01_11;
          5'd13:   e = 9'b1_10_00_11_01;
          5'd14:   e = 9'b1_10_01_00_11;
          5'd15:   e = 9'b0_10_01_11_00;
          5'd16:   e = 9'b0_10_11_00_01;
          5'd17:   e = 9'b1_10_11_01_00;
          5'd18:   e = 9'b1_11_00_01_10;
          5'd19:   e = 9'b0_11_00_10_01;
          5'd20:   e = 9'b0_11_01_00_10;
          5'd21:   e = 9'b1_11_01_10_00;
          5'd22:   e = 9'b1_11_10_00_01;
          default: e = 9'b0_11_10_01_00;
        endcase
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/det_seq_if.sv
// Request/result bundle between the matrix coprocessor and det_seq.
interface det_seq_if #(parameter int DATA_W = 8);
  localparam int ACC_W = 4*DATA_W + 6;

  logic                     start;
  logic [1:0]               size;
  logic [16*DATA_W-1:0]     matrix;
  logic                     busy;
  logic                     done;
  logic signed [DATA_W-1:0] det;
  logic signed [ACC_W-1:0]  det_full;
  logic                     ovf;
  logic                     iovf;

  modport master (
    output start, size, matrix,
    input  busy, done, det, det_full, ovf, iovf
  );

  modport slave (
    input  start, size, matrix,
    output busy, done, det, det_full, ovf, iovf
  );
endinterface

// File: rtl/det_term.sv
// One signed Leibniz term: product of the selected element of each active row,
// with factors of inactive rows forced to 1, negated for odd permutations.
module det_term #(
  parameter int DATA_W = 8
) (
  input  logic [16*DATA_W-1:0]         mat,
  input  logic [1:0]                   size,
  input  logic [7:0]                   cols,
  input  logic                         odd,
  output logic signed [4*DATA_W+5:0]   term
);
  localparam int ACC_W = 4*DATA_W + 6;

  logic signed [ACC_W-1:0] fac [4];
  logic signed [ACC_W-1:0] prod;

  for (genvar i = 0; i < 4; i++) begin : g_fac
    logic [1:0]               c;
    logic signed [DATA_W-1:0] e;

    assign c = cols[7-2*i -: 2];

    // a00 sits in the MSB element, so element (r,c) is at slot 15-(4r+c).
    always_comb begin
      case (c)
        2'd0:    e = mat[(15-4*i)*DATA_W +: DATA_W];
        2'd1:    e = mat[(14-4*i)*DATA_W +: DATA_W];
        2'd2:    e = mat[(13-4*i)*DATA_W +: DATA_W];
        default: e = mat[(12-4*i)*DATA_W +: DATA_W];
      endcase
    end

    assign fac[i] = (size >= 2'(i)) ? {{(ACC_W-DATA_W){e[DATA_W-1]}}, e}
                                    : {{(ACC_W-1){1'b0}}, 1'b1};
  end

  assign prod = fac[0] * fac[1] * fac[2] * fac[3];
  assign term = odd ? -prod : prod;
endmodule

// File: rtl/det_seq.sv
// Sequential signed determinant: accumulates one Leibniz term per clock after
// start, then pulses done with truncated/full results and overflow flags.
import det_pkg::*;

module det_seq #(
  parameter int DATA_W = 8
) (
  input  logic   clk,
  input  logic   rst,
  det_seq_if.slave bus
);
  localparam int ACC_W = 4*DATA_W + 6;
  localparam logic signed [ACC_W-1:0] DMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] DMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic fits_dw(input logic signed [ACC_W-1:0] x);
    return (x >= DMIN) && (x <= DMAX);
  endfunction

  // Magnitude test: a term of exactly -2^(DATA_W-1) already counts as out of range.
  function automatic logic mag_fits_dw(input logic signed [ACC_W-1:0] x);
    return (x >= -DMAX) && (x <= DMAX);
  endfunction

  state_t                   state;
  logic [4:0]               k;
  logic [1:0]               size_l;
  logic [16*DATA_W-1:0]     mat_l;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [8:0]               pe;
  logic                     last_term;
  logic signed [DATA_W-1:0] det_r;
  logic signed [ACC_W-1:0]  det_full_r;
  logic                     ovf_r;
  logic                     iovf_r;

  assign pe        = perm_entry(size_l, k);
  assign acc_nxt   = acc + term;
  assign last_term = (k == term_count(size_l) - 5'd1);

  det_term #(.DATA_W(DATA_W)) u_term (
    .mat  (mat_l),
    .size (size_l),
    .cols (pe[7:0]),
    .odd  (pe[8]),
    .term (term)
  );

  // Operand capture: only the copy taken at the accepted start is used during RUN.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      mat_l  <= bus.matrix;
      size_l <= bus.size;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      k          <= '0;
      acc        <= '0;
      det_r      <= '0;
      det_full_r <= '0;
      ovf_r      <= 1'b0;
      iovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= RUN;
            k          <= '0;
            acc        <= '0;
            det_r      <= '0;
            det_full_r <= '0;
            ovf_r      <= 1'b0;
            iovf_r     <= 1'b0;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          iovf_r <= iovf_r | ~mag_fits_dw(term) | ~fits_dw(acc_nxt);
          if (last_term) begin
            state      <= DONE;
            det_full_r <= acc_nxt;
            det_r      <= acc_nxt[DATA_W-1:0];
            ovf_r      <= ~fits_dw(acc_nxt);
          end else begin
            k <= k + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.det      = det_r;
  assign bus.det_full = det_full_r;
  assign bus.ovf      = ovf_r;
  assign bus.iovf     = iovf_r;
endmodule

// File: tb/tb_det_seq.sv
// Randomised and directed bench for det_seq; expectations come from a
// permutation-enumerating reference model and are checked by a done monitor.
module tb_det_seq;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  det_seq_if #(.DATA_W(DW)) bus ();

  det_seq #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    longint full;
    bit     ovf;
    bit     iovf;
    int     lat;
    int     start_cyc;
  } exp_t;

  exp_t q[$];
  exp_t last;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic longint elem(input logic [127:0] m, input int r, input int c);
    logic signed [7:0] v;
    v = m[(15-(r*4+c))*8 +: 8];
    return longint'(v);
  endfunction

  // Leibniz sum over all permutations in lexicographic order, tracking the
  // term magnitude and every running sum against the 8-bit signed range.
  function automatic exp_t model(input logic [127:0] m, input int n);
    exp_t   e;
    int     p[4];
    longint acc, term;
    int     inv, i, j, tmp, lo, hi;
    bit     more, iovf;
    acc = 0; iovf = 0; more = 1;
    for (int a = 0; a < 4; a++) p[a] = a;
    while (more) begin
      term = 1; inv = 0;
      for (int r = 0; r < n; r++) begin
        term *= elem(m, r, p[r]);
        for (int s = 0; s < r; s++) if (p[s] > p[r]) inv++;
      end
      if (inv % 2 == 1) term = -term;
      if (term > 127 || term < -127) iovf = 1;
      acc += term;
      if (acc > 127 || acc < -128) iovf = 1;
      i = n - 2;
      while (i >= 0 && p[i] >= p[i+1]) i--;
      if (i < 0) more = 0;
      else begin
        j = n - 1;
        while (p[j] <= p[i]) j--;
        tmp = p[i]; p[i] = p[j]; p[j] = tmp;
        lo = i + 1; hi = n - 1;
        while (lo < hi) begin
          tmp = p[lo]; p[lo] = p[hi]; p[hi] = tmp;
          lo++; hi--;
        end
      end
    end
    e.full = acc;
    e.ovf  = (acc > 127 || acc < -128);
    e.iovf = iovf;
    e.lat  = (n == 1) ? 1 : (n == 2) ? 2 : (n == 3) ? 6 : 24;
    e.start_cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic signed [7:0] d8;
    if (rst && bus.done) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done: done=1 required 0");
      end else begin
        e  = q.pop_front();
        d8 = e.full[7:0];
        chk("latency", longint'(cyc - e.start_cyc), longint'(e.lat));
        chk("det_full", longint'(bus.det_full), e.full);
        chk("det", longint'(bus.det), longint'(d8));
        chk("ovf", longint'(bus.ovf), longint'(e.ovf));
        chk("iovf", longint'(bus.iovf), longint'(e.iovf));
        chk("busy_in_done", longint'(bus.busy), 0);
        last = e;
      end
    end
  end

  task automatic issue(input logic [127:0] m, input logic [1:0] sz, input bit dbl);
    exp_t e;
    @(negedge clk);
    bus.matrix = m; bus.size = sz; bus.start = 1'b1;
    e = model(m, int'(sz) + 1);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.matrix = {$urandom, $urandom, $urandom, $urandom};
    bus.size   = 2'($urandom);
    e.start_cyc = cyc;
    q.push_back(e);
    chk("busy_after_start", longint'(bus.busy), 1);
    chk("clear_det_full", longint'(bus.det_full), 0);
    chk("clear_iovf", longint'(bus.iovf), 0);
    if (dbl) begin
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int t = 0; t < 40 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end else begin
      repeat (2) @(negedge clk);
      chk("hold_det_full", longint'(bus.det_full), last.full);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ma, mb, mc, md, me, mr;
    logic [1:0]   sz;
    int           v;
    ma = {8'd2,8'd3,8'd2,8'd1, 8'd1,8'd2,8'd2,8'd1, 8'd0,8'd4,8'd1,8'd2, 8'd3,8'd5,8'd1,8'd1};
    mb = {8'd2,8'd3,8'd4,8'd3, 8'd1,8'd6,8'd4,8'd5, 8'd3,8'd0,8'd9,8'd8, 8'd1,8'd2,8'd1,8'd1};
    mc = {8'd127,8'd127,8'd0,8'd0, 8'h80,8'd127,8'd0,8'd0, 64'd0};
    md = {8'd2,8'd0,8'd0,8'd7, 8'd0,8'd3,8'd0,8'd7, 8'd0,8'd0,8'd4,8'd7, 8'd7,8'd7,8'd7,8'd7};
    me = {8'hFB, {15{8'h11}}};

    bus.start = 1'b0; bus.size = 2'd0; bus.matrix = '0;
    #2;
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_det", longint'(bus.det), 0);
    chk("rst_det_full", longint'(bus.det_full), 0);
    chk("rst_ovf", longint'(bus.ovf), 0);
    chk("rst_iovf", longint'(bus.iovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    issue(ma, 2'd3, 1'b0);
    issue(mb, 2'd3, 1'b0);
    issue(mc, 2'd1, 1'b0);
    issue(md, 2'd2, 1'b0);
    issue(me, 2'd0, 1'b0);
    issue(ma, 2'd3, 1'b1);

    // Abort a 4x4 run with reset mid-flight; no done may follow.
    @(negedge clk);
    bus.matrix = mb; bus.size = 2'd3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_done", longint'(bus.done), 0);
    chk("abort_det", longint'(bus.det), 0);
    chk("abort_det_full", longint'(bus.det_full), 0);
    chk("abort_ovf", longint'(bus.ovf), 0);
    chk("abort_iovf", longint'(bus.iovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    issue(md, 2'd2, 1'b0);

    for (int n = 0; n < 30; n++) begin
      sz = 2'($urandom_range(0, 3));
      mr = '0;
      for (int e = 0; e < 16; e++) begin
        v = ($urandom_range(0, 1) == 1) ? ($urandom_range(0, 6) - 3) : $urandom_range(0, 255);
        mr[(15-e)*8 +: 8] = 8'(v);
      end
      issue(mr, sz, (sz == 2'd3) && ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/det_seq.md
Name: det_seq

Overview:
Sequential, parametrised signed determinant engine for the matrix coprocessor; successor to the combinational 4x4 determinant.
- Selectable matrix order 1..4 and parametrised element width.
- Computes by Leibniz expansion: one signed permutation term accumulated per clock, behind a start/done handshake.
- Reports the truncated result, the full-width result, a final-overflow flag and an intermediate-overflow flag.

Parameters:
DATA_W, 8, element and result width (signed).
ACC_W, 4*DATA_W+6, accumulator/product width; derived localparam, not overridable.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
size  in  2  matrix order minus one (0=1x1 .. 3=4x4).
matrix  in  16*DATA_W  signed 4x4, row-major; a00 in the MSB element, a33 in the LSB element. Order n uses the top-left n x n.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse; results valid from this cycle.
det  out  DATA_W  low DATA_W bits of the determinant.
det_full  out  ACC_W  exact signed determinant.
ovf  out  1  det_full outside the signed DATA_W range.
iovf  out  1  any term product or running sum left the signed DATA_W range.

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, det, det_full, ovf, iovf all 0; term index 0; accumulator 0.
- Reset while in RUN aborts the computation with no done.
- IDLE: start=1 at a rising edge →
  - latch matrix and size;
  - clear accumulator and iovf;
  - k=0; go to RUN.
- RUN, each edge:
  - term = sign[k] * product of a[i][perm[k][i]] for i<n, computed at ACC_W;
  - acc += term;
  - k++.
  - Number of terms T = n! (1, 2, 6, 24); the permutation table is per-order.
- iovf is sticky per operation: set if |term| or the updated acc falls outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- On the edge that accumulates term T-1: state → DONE; det_full, det and ovf are registered from the final acc.
- Latency: done is high T cycles after the start-sampling edge (24 for 4x4).
- DONE: lasts exactly 1 cycle (done=1, busy=0), then → IDLE.
- Output holding: det, det_full, ovf and iovf hold until the next accepted start. On that start they clear to 0, together with the accumulator and iovf.
- start while in RUN or DONE is ignored; it is not queued.
- The matrix and size inputs may change freely after the start edge; only the latched copy is used.
- Arithmetic:
  - Elements are sign-extended to ACC_W before multiplying.
  - ACC_W is sized so that 24 * (2^(DATA_W-1))^4 never wraps.
  - det is a plain truncation, never saturated.

Decomposition:
- Package det_pkg:
  - state enum (IDLE, RUN, DONE);
  - permutation tables for orders 1–4 as 2-bit column indices;
  - per-term parity bits;
  - term counts per order.
- One sub-module, det_term: combinational product of up to 4 selected elements. Unused factors for order n<4 are forced to 1. It also applies the sign.

Test Plan:
- 4x4, size=3, matrix 2,3,2,1 / 1,2,2,1 / 0,4,1,2 / 3,5,1,1 (8-bit) → done 24 cycles after start; det=1; det_full=1; ovf=0.
- 4x4 matrix 2,3,4,3 / 1,6,4,5 / 3,0,9,8 / 1,2,1,1 → det=37, ovf=0, iovf=1 (the term 3*6*9*1=162 exceeds 127).
- 2x2, size=1, matrix 127,127 / -128,127 → det_full=32385, det=0x81 (-127), ovf=1, iovf=1, done after 2 cycles.
- 3x3, size=2, diag(2,3,4) with other elements nonzero beyond the 3x3 → det=24, ovf=0, iovf=0, done after 6 cycles; elements outside the 3x3 are ignored.
- 1x1, size=0, a00=-5 → det=-5, done 1 cycle after start. A second start pulsed while busy during a 4x4 run → ignored: exactly one done, with the first operation's result.
- Reset asserted at cycle 10 of a 4x4 run → all outputs 0 immediately, no done. A new start after release → correct result, with iovf not carried over.
